// File: rtl/core_bus_pkg.sv
// core_bus_pkg: definitions shared by the memory-port arbiter and its helpers.
//   MT_*         funct3 size/sign codes used on the request and memory sides
//   LED_ADDR     MMIO address of the LED word
//   state_t      arbiter FSM state encoding
//   misaligned() true when an access of the given size code is not naturally aligned
package core_bus_pkg;

  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_W  = 3'b010;
  localparam logic [2:0] MT_BU = 3'b100;
  localparam logic [2:0] MT_HU = 3'b101;

  localparam logic [31:0] LED_ADDR = 32'h0000_4000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Words need a 4-byte boundary, halfwords a 2-byte boundary; bytes are always fine.
  function automatic logic misaligned(input logic [2:0] mtype, input logic [31:0] addr);
    logic bad;
    case (mtype)
      MT_W:        bad = (addr[1:0] != 2'b00);
      MT_H, MT_HU: bad = addr[0];
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin selector.
//   req[1:0]  request vector, bit 1 = data requester, bit 0 = fetch requester
//   last      1 when the data requester won the previous grant
//   sel       1 selects the data requester, 0 the fetch requester
//   gnt[1:0]  one-hot grant, zero when nothing is requested
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie the side that did not win last time goes.
  always_comb begin
    sel = (req == 2'b11) ? ~last : req[1];
    gnt = 2'b00;
    if (req[1] && sel) begin
      gnt = 2'b10;
    end else if (req[0] && !sel) begin
      gnt = 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch and
// load/store, decodes the MMIO LED word and rejects misaligned accesses locally.
//   clk, rst                     clock, synchronous active-high reset
//   f_req/f_addr                 fetch request (always a word load)
//   d_req/d_load/d_store/d_addr/d_type/d_wdata   data request
//   f_gnt, d_gnt                 one-cycle accept pulses
//   rsp_valid/rsp_to_d/rsp_rdata/rsp_err         one-cycle response
//   mem_load/mem_store/mem_type/mem_addr/mem_data  memory command (only in MEM)
//   mem_out, mem_stall           memory read data and busy
//   led_word                     LED register
//   busy                         high whenever an access is in flight
module mem_port_arbiter
  import core_bus_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic        d_req,
  input  logic        d_load,
  input  logic        d_store,
  input  logic [31:0] f_addr,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_type,
  input  logic [31:0] d_wdata,
  output logic        f_gnt,
  output logic        d_gnt,
  output logic        rsp_valid,
  output logic        rsp_to_d,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_load,
  output logic        mem_store,
  output logic [2:0]  mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_out,
  input  logic        mem_stall,
  output logic [31:0] led_word,
  output logic        busy
);

  state_t      state_q, state_d;
  logic        last_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  type_q;
  logic        store_q, owner_q, err_q;

  logic        in_idle;
  logic        pick_sel;
  logic [1:0]  pick_gnt;
  logic        win_any, win_store, win_err, win_ram, win_led;
  logic [31:0] win_addr, win_wdata;
  logic [2:0]  win_type;

  // Requests only compete while idle and out of reset, so no grant can appear elsewhere.
  assign in_idle = (state_q == ST_IDLE) && !rst;

  rr_pick2 u_pick (
    .req  ({d_req & in_idle, f_req & in_idle}),
    .last (last_d),
    .sel  (pick_sel),
    .gnt  (pick_gnt)
  );

  // Winner's command; store data is kept only for stores so loads drive zero data.
  assign win_any   = |pick_gnt;
  assign win_addr  = pick_sel ? d_addr : f_addr;
  assign win_type  = pick_sel ? d_type : MT_W;
  assign win_store = pick_sel & d_store & ~d_load;
  assign win_wdata = win_store ? d_wdata : 32'h0;
  assign win_err   = misaligned(win_type, win_addr);
  assign win_ram   = (win_addr[31:MEM_ADDR_BITS] == '0);
  assign win_led   = (win_addr == LED_ADDR);

  assign busy = (state_q != ST_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only well-aligned RAM accesses visit MEM; MMIO and rejected accesses answer next cycle.
  always_comb begin
    state_d   = state_q;
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_load  = 1'b0;
    mem_store = 1'b0;
    mem_type  = 3'b000;
    mem_addr  = 32'h0;
    mem_data  = 32'h0;
    rsp_valid = 1'b0;
    rsp_to_d  = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          f_gnt = pick_gnt[0];
          d_gnt = pick_gnt[1];
          if (win_any) begin
            state_d = (!win_err && win_ram) ? ST_MEM : ST_RESP;
          end
        end
        ST_MEM: begin
          mem_load  = !store_q;
          mem_store = store_q;
          mem_type  = type_q;
          mem_addr  = addr_q;
          mem_data  = wdata_q;
          if (!mem_stall) begin
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid = 1'b1;
          rsp_to_d  = owner_q;
          rsp_rdata = rdata_q;
          rsp_err   = err_q;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Command latch, response data and LED register. MMIO effects happen on the grant
  // edge so the response is ready one cycle later; RAM data is taken on the unstalled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d   <= 1'b0;
      owner_q  <= 1'b0;
      addr_q   <= 32'h0;
      type_q   <= 3'b000;
      store_q  <= 1'b0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      led_word <= 32'h0;
    end else if (win_any) begin
      last_d  <= pick_sel;
      owner_q <= pick_sel;
      addr_q  <= win_addr;
      type_q  <= win_type;
      store_q <= win_store;
      wdata_q <= win_wdata;
      err_q   <= win_err;
      rdata_q <= 32'h0;
      if (!win_err && !win_ram && win_led) begin
        if (win_store) begin
          led_word <= win_wdata;
        end else begin
          rdata_q <= led_word;
        end
      end
    end else if (state_q == ST_MEM && !mem_stall) begin
      rdata_q <= store_q ? 32'h0 : mem_out;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with literal expectations, then randomized
// requesters, stalls and resets, all compared every cycle against a transaction model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_load, d_store;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic [2:0]  d_type;
  logic        f_gnt, d_gnt, rsp_valid, rsp_to_d, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_load, mem_store;
  logic [2:0]  mem_type;
  logic [31:0] mem_addr, mem_data, mem_out;
  logic        mem_stall;
  logic [31:0] led_word;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .d_req     (d_req),
    .d_load    (d_load),
    .d_store   (d_store),
    .f_addr    (f_addr),
    .d_addr    (d_addr),
    .d_type    (d_type),
    .d_wdata   (d_wdata),
    .f_gnt     (f_gnt),
    .d_gnt     (d_gnt),
    .rsp_valid (rsp_valid),
    .rsp_to_d  (rsp_to_d),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_load  (mem_load),
    .mem_store (mem_store),
    .mem_type  (mem_type),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_out   (mem_out),
    .mem_stall (mem_stall),
    .led_word  (led_word),
    .busy      (busy)
  );

  int total = 0;
  int bad = 0;

  // Transaction model: one access at a time, either waiting on memory or owing a response.
  bit          m_in_mem, m_rsp_due, m_last_d, m_to_d, m_store, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata, m_led;
  logic [2:0]  m_type;
  bit          m_f_granted, m_d_granted;

  logic [2:0]  types [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [1:0]  eg;
    logic [4:0]  ecmd;
    logic [31:0] eaddr, edata, nxt_led;
    bit          erv, take_d;
    m_f_granted = 0;
    m_d_granted = 0;
    if (rst) begin
      m_in_mem  = 0;
      m_rsp_due = 0;
      m_last_d  = 0;
      m_led     = 32'h0;
      return;
    end
    eg = 2'b00; ecmd = 5'b0; eaddr = 32'h0; edata = 32'h0; erv = 0;
    nxt_led = m_led;
    check("led_word", led_word, m_led);
    check("busy", busy, m_in_mem | m_rsp_due);
    if (m_rsp_due) begin
      erv = 1;
      m_rsp_due = 0;
    end else if (m_in_mem) begin
      ecmd  = {!m_store, m_store, m_type};
      eaddr = m_addr;
      edata = m_store ? m_wdata : 32'h0;
      if (!mem_stall) begin
        m_rdata   = m_store ? 32'h0 : mem_out;
        m_in_mem  = 0;
        m_rsp_due = 1;
      end
    end else if (f_req || d_req) begin
      take_d      = d_req && (!f_req || !m_last_d);
      eg          = take_d ? 2'b10 : 2'b01;
      m_last_d    = take_d;
      m_to_d      = take_d;
      m_f_granted = !take_d;
      m_d_granted = take_d;
      m_addr  = take_d ? d_addr : f_addr;
      m_type  = take_d ? d_type : 3'b010;
      m_store = take_d && d_store;
      m_wdata = m_store ? d_wdata : 32'h0;
      m_err   = (m_addr % (32'd1 << m_type[1:0])) != 0;
      m_rdata = 32'h0;
      if (m_err) begin
        m_rsp_due = 1;
      end else if (m_addr < 32'h4000) begin
        m_in_mem = 1;
      end else begin
        if (m_addr == 32'h4000) begin
          if (m_store) nxt_led = m_wdata;
          else m_rdata = m_led;
        end
        m_rsp_due = 1;
      end
    end
    check("grant", {d_gnt, f_gnt}, eg);
    check("mem_cmd", {mem_load, mem_store, mem_type}, ecmd);
    check("mem_addr", mem_addr, eaddr);
    check("mem_data", mem_data, edata);
    check("rsp_valid", rsp_valid, erv);
    if (erv) begin
      check("rsp_to_d", rsp_to_d, m_to_d);
      check("rsp_err", rsp_err, m_err);
      check("rsp_rdata", rsp_rdata, m_rdata);
    end
    m_led = nxt_led;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0: a = 32'h4000;
      1: a = 32'h4004;
      2: a = $urandom | 32'h8000_0000;
      default: begin
        a = $urandom_range(0, 16383);
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      end
    endcase
    return a;
  endfunction

  task automatic applyStimulus();
    if (!f_req && $urandom_range(0, 2) == 0) begin
      f_req  = 1;
      f_addr = rand_addr();
    end
    if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req   = 1;
      d_addr  = rand_addr();
      d_type  = types[$urandom_range(0, 4)];
      {d_load, d_store} = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      d_wdata = $urandom;
    end
    mem_stall = ($urandom_range(0, 3) == 0);
    mem_out   = $urandom;
    rst       = ($urandom_range(0, 499) == 0);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    checkOutput();
    @(posedge clk);
    #1;
    if (m_f_granted) f_req = 0;
    if (m_d_granted) begin
      d_req = 0; d_load = 0; d_store = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    settle();
    advance();
    rst = 0;
  endtask

  initial begin
    rst = 1; f_req = 0; d_req = 0; d_load = 0; d_store = 0;
    f_addr = 0; d_addr = 0; d_type = 3'b010; d_wdata = 0;
    mem_out = 0; mem_stall = 0;
    #1;

    // Single fetch from the top of RAM.
    do_reset();
    settle();
    check("reset_outputs", {busy, f_gnt, d_gnt, rsp_valid, mem_load, mem_store}, 6'b0);
    check("reset_led", led_word, 32'h0);
    advance();
    f_req = 1; f_addr = 32'h3ff8; mem_stall = 0; mem_out = 32'h13;
    settle(); check("fetch_gnt", f_gnt, 1'b1); advance();
    settle();
    check("fetch_mem_load", mem_load, 1'b1);
    check("fetch_mem_addr", mem_addr, 32'h3ff8);
    check("fetch_mem_type", mem_type, 3'b010);
    advance();
    settle();
    check("fetch_rsp", {rsp_valid, rsp_to_d}, 2'b10);
    check("fetch_rdata", rsp_rdata, 32'h13);
    advance();

    // Tie with both requests held: data, fetch, data; silence in MEM and RESP.
    do_reset();
    f_addr = 32'h40; d_addr = 32'h80; d_type = 3'b010; d_store = 0;
    for (int k = 0; k < 3; k++) begin
      f_req = 1; d_req = 1; d_load = 1;
      settle(); check("tie_order", {d_gnt, f_gnt}, (k == 1) ? 2'b01 : 2'b10); advance();
      for (int j = 0; j < 2; j++) begin
        f_req = 1; d_req = 1; d_load = 1;
        settle(); check("tie_no_gnt", {d_gnt, f_gnt}, 2'b00); advance();
      end
    end
    f_req = 0; d_req = 0; d_load = 0;

    // Stalled store: command stable for five MEM cycles, one response at N+6.
    d_req = 1; d_store = 1; d_load = 0; d_addr = 32'h100; d_type = 3'b010;
    d_wdata = 32'hDEADBEEF; mem_stall = 0;
    settle(); check("stall_gnt", d_gnt, 1'b1); advance();
    for (int i = 0; i < 5; i++) begin
      mem_stall = (i < 4);
      settle();
      check("stall_cmd", {mem_load, mem_store, mem_type}, 5'b01010);
      check("stall_addr", mem_addr, 32'h100);
      check("stall_data", mem_data, 32'hDEADBEEF);
      check("stall_no_rsp", rsp_valid, 1'b0);
      advance();
    end
    mem_stall = 0;
    settle(); check("stall_rsp", rsp_valid, 1'b1); advance();
    settle(); check("stall_rsp_once", rsp_valid, 1'b0); advance();

    // MMIO LED store, readback, and an unmapped MMIO read.
    d_req = 1; d_store = 1; d_load = 0; d_addr = 32'h4000; d_wdata = 32'h12345678;
    settle(); check("mmio_gnt", d_gnt, 1'b1); check("mmio_no_store", mem_store, 1'b0); advance();
    settle();
    check("mmio_led", led_word, 32'h12345678);
    check("mmio_rsp", rsp_valid, 1'b1);
    check("mmio_no_store2", mem_store, 1'b0);
    advance();
    d_req = 1; d_load = 1; d_store = 0; d_addr = 32'h4000;
    settle(); advance();
    settle(); check("mmio_read_led", {rsp_valid, rsp_rdata}, {1'b1, 32'h12345678}); advance();
    d_req = 1; d_load = 1; d_store = 0; d_addr = 32'h4004;
    settle(); advance();
    settle(); check("mmio_read_other", {rsp_valid, rsp_rdata}, {1'b1, 32'h0}); advance();

    // Misaligned word and halfword loads.
    for (int c = 0; c < 2; c++) begin
      d_req = 1; d_load = 1; d_store = 0;
      d_addr = (c == 0) ? 32'h102 : 32'h101;
      d_type = (c == 0) ? 3'b010 : 3'b001;
      settle(); check("mis_no_mem", {mem_load, mem_store}, 2'b00); advance();
      settle();
      check("mis_err", {rsp_valid, rsp_err}, 2'b11);
      check("mis_no_mem2", {mem_load, mem_store, mem_addr}, 34'h0);
      advance();
    end

    // Reset during a stalled load.
    d_req = 1; d_load = 1; d_store = 0; d_addr = 32'h200; d_type = 3'b010; mem_stall = 1;
    settle(); advance();
    settle(); check("rmid_in_mem", mem_load, 1'b1); advance();
    rst = 1;
    settle(); advance();
    rst = 0;
    settle();
    check("rmid_idle", busy, 1'b0);
    check("rmid_mem_load", mem_load, 1'b0);
    check("rmid_led", led_word, 32'h0);
    advance();
    mem_stall = 0;
    for (int i = 0; i < 3; i++) begin
      settle(); check("rmid_no_rsp", rsp_valid, 1'b0); advance();
    end
    f_req = 1; f_addr = 32'h0; d_req = 1; d_load = 1; d_store = 0; d_addr = 32'h300;
    settle(); check("rmid_tie", {d_gnt, f_gnt}, 2'b10); advance();

    // Randomized traffic with stalls and occasional resets.
    repeat (3000) begin
      applyStimulus();
      settle();
      advance();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
